// File: rtl/mem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_pkg
//   Shared definitions for the memory-stage controller of the 5-stage
//   pipeline: default widths, FSM state encodings, RegSrc encodings and a
//   small helper that classifies an access as illegal.
// ---------------------------------------------------------------------------
package mem_access_ctrl_pkg;

  // Default datapath widths.
  localparam int DATA_W_DEF  = 16;
  localparam int WREG_W_DEF  = 3;
  localparam int TIMEOUT_DEF = 63;

  // Controller state encodings (2 bits, kept as plain constants so older
  // tooling and waveform scripts see stable values).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  // Write-back source select carried through to MEM/WB.
  localparam logic [1:0] RS_ALU = 2'd0;
  localparam logic [1:0] RS_MEM = 2'd1;
  localparam logic [1:0] RS_PC  = 2'd2;
  localparam logic [1:0] RS_B   = 2'd3;

  // An access is illegal when it targets an odd byte address or when the
  // decoder asked for a load and a store at the same time.
  function automatic logic bad_access(input logic addr_lsb,
                                      input logic is_rd,
                                      input logic is_wr);
    return addr_lsb | (is_rd & is_wr);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_dff.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_dff
//   Generic D flip-flop cell with asynchronous active-low reset to a
//   parameterised value. Used for the controller state register.
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   async active-low reset
//   i_d    in   W  next value
//   o_q    out  W  registered value
// ---------------------------------------------------------------------------
module mem_access_ctrl_dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples its inputs before any of them update in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= RST_VAL;
    else        r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// ---------------------------------------------------------------------------
// mem_timeout_cnt
//   Clearable, enabled, saturating up-counter with an expiry flag. Counts
//   the cycles the controller spends waiting for the data memory.
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   async active-low reset (count -> 0)
//   i_clr     in   synchronous clear (wins over i_en)
//   i_en      in   count this cycle
//   o_expire  out  this enabled cycle brings the count to MAX
// ---------------------------------------------------------------------------
module mem_timeout_cnt #(
  parameter int MAX = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int               CNT_W  = $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(MAX - 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at MAX so a stuck enable can never wrap back to a small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (i_clr)                   r_cnt <= '0;
    else if (i_en && r_cnt != MAX_V)  r_cnt <= r_cnt + 1'b1;
  end

  // Flag the cycle whose increment reaches MAX, so the owner can leave on
  // the same edge instead of spending one extra cycle waiting.
  assign o_expire = i_en && (r_cnt >= LAST_V);

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Memory-stage controller between EX/MEM and MEM/WB. Issues one load or
//   store at a time to a multi-cycle data memory, freezes the upstream
//   pipeline while the access is pending, and hands read data plus the
//   EX/MEM passthrough fields to MEM/WB. Misaligned or contradictory
//   accesses, memory-reported errors and timeouts lock the controller into
//   a sticky error state that only reset clears.
// Ports
//   clk, rst_n                     clock / async active-low reset
//   in_valid                       EX/MEM holds a real instruction
//   MemRead_in, MemWrite_in        load / store request
//   addr_in, wdata_in              effective address / store data
//   alu_in, pc_in, Binput_in,
//   RegSrc_in, RegWrt_in, wreg_in  fields passed straight to MEM/WB
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                      request to the data memory
//   mem_rdata, mem_done, mem_err   response from the data memory
//   MemRead_out                    load data (0 for non-loads)
//   alu_out .. wreg_out            passthrough to MEM/WB
//   out_valid                      MEM/WB may capture this cycle
//   stall_out                      freeze PC, IF/ID, ID/EX, EX/MEM
//   err_out                        sticky error
// ---------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int WREG_W  = WREG_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] Binput_in,
  input  logic [1:0]        RegSrc_in,
  input  logic              RegWrt_in,
  input  logic [WREG_W-1:0] wreg_in,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_err,
  output logic [DATA_W-1:0] MemRead_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] Binput_out,
  output logic [1:0]        RegSrc_out,
  output logic              RegWrt_out,
  output logic [WREG_W-1:0] wreg_out,
  output logic              out_valid,
  output logic              stall_out,
  output logic              err_out
);

  logic [1:0] w_state;
  logic [1:0] w_state_nxt;
  logic       w_mem_op;
  logic       w_bad;
  logic       w_issue;
  logic       w_rd_sel;
  logic       w_cnt_clr;
  logic       w_cnt_en;
  logic       w_expire;

  mem_access_ctrl_dff #(
    .W       (2),
    .RST_VAL (ST_IDLE)
  ) u_state_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_state_nxt),
    .o_q   (w_state)
  );

  mem_timeout_cnt #(
    .MAX (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_expire (w_expire)
  );

  assign w_mem_op = in_valid & (MemRead_in | MemWrite_in);
  assign w_bad    = bad_access(addr_in[0], MemRead_in, MemWrite_in);

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = w_state;
    w_issue     = 1'b0;
    w_rd_sel    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    out_valid   = 1'b0;
    stall_out   = 1'b0;

    case (w_state)
      ST_IDLE: begin
        if (!w_mem_op) begin
          out_valid = in_valid;
        end else if (w_bad) begin
          // Illegal access never reaches the memory.
          stall_out   = 1'b1;
          w_state_nxt = ST_ERR;
        end else begin
          w_issue = 1'b1;
          if (mem_err) begin
            // Error outranks a same-cycle completion.
            stall_out   = 1'b1;
            w_state_nxt = ST_ERR;
          end else if (mem_done) begin
            // Hit in the issue cycle: no added latency.
            out_valid = 1'b1;
            w_rd_sel  = MemRead_in;
          end else begin
            stall_out   = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        w_cnt_en = 1'b1;
        if (mem_err) begin
          stall_out   = 1'b1;
          w_state_nxt = ST_ERR;
        end else if (mem_done) begin
          // EX/MEM is frozen, so MemRead_in still describes this access.
          out_valid   = 1'b1;
          w_rd_sel    = MemRead_in;
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          stall_out   = 1'b1;
          w_state_nxt = ST_ERR;
        end else begin
          stall_out = 1'b1;
        end
      end

      ST_ERR: begin
        stall_out = 1'b1;
      end

      default: begin
        // Unreachable encoding: fail safe into the error state.
        stall_out   = 1'b1;
        w_state_nxt = ST_ERR;
      end
    endcase
  end

  // Memory request.
  assign mem_en    = w_issue;
  assign mem_wr    = w_issue & MemWrite_in;
  assign mem_addr  = addr_in;
  assign mem_wdata = wdata_in;

  // MEM/WB side.
  assign MemRead_out = w_rd_sel ? mem_rdata : '0;
  assign alu_out     = alu_in;
  assign pc_out      = pc_in;
  assign Binput_out  = Binput_in;
  assign RegSrc_out  = RegSrc_in;
  assign RegWrt_out  = RegWrt_in;
  assign wreg_out    = wreg_in;

  assign err_out = (w_state == ST_ERR);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Self-checking bench for mem_access_ctrl. Expected MEM/WB results are
//   pushed to a scoreboard queue when an instruction is driven and popped by
//   a monitor whenever out_valid is seen. Control outputs are checked
//   directly against constants.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int WW = 3;
  localparam int TO = 5;

  typedef struct {
    logic [DW-1:0] alu;
    logic [DW-1:0] pc;
    logic [DW-1:0] b;
    logic [DW-1:0] rd;
    logic [1:0]    regsrc;
    logic          regwrt;
    logic [WW-1:0] wreg;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, MemRead_in, MemWrite_in;
  logic [DW-1:0] addr_in, wdata_in, alu_in, pc_in, Binput_in;
  logic [1:0]    RegSrc_in;
  logic          RegWrt_in;
  logic [WW-1:0] wreg_in;
  logic          mem_en, mem_wr;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_done, mem_err;
  logic [DW-1:0] MemRead_out, alu_out, pc_out, Binput_out;
  logic [1:0]    RegSrc_out;
  logic          RegWrt_out;
  logic [WW-1:0] wreg_out;
  logic          out_valid, stall_out, err_out;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .DATA_W  (DW),
    .WREG_W  (WW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .MemRead_in  (MemRead_in),
    .MemWrite_in (MemWrite_in),
    .addr_in     (addr_in),
    .wdata_in    (wdata_in),
    .alu_in      (alu_in),
    .pc_in       (pc_in),
    .Binput_in   (Binput_in),
    .RegSrc_in   (RegSrc_in),
    .RegWrt_in   (RegWrt_in),
    .wreg_in     (wreg_in),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_done    (mem_done),
    .mem_err     (mem_err),
    .MemRead_out (MemRead_out),
    .alu_out     (alu_out),
    .pc_out      (pc_out),
    .Binput_out  (Binput_out),
    .RegSrc_out  (RegSrc_out),
    .RegWrt_out  (RegWrt_out),
    .wreg_out    (wreg_out),
    .out_valid   (out_valid),
    .stall_out   (stall_out),
    .err_out     (err_out)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: every out_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("alu_out",     alu_out,     mon_e.alu);
        check("pc_out",      pc_out,      mon_e.pc);
        check("Binput_out",  Binput_out,  mon_e.b);
        check("MemRead_out", MemRead_out, mon_e.rd);
        check("RegSrc_out",  RegSrc_out,  mon_e.regsrc);
        check("RegWrt_out",  RegWrt_out,  mon_e.regwrt);
        check("wreg_out",    wreg_out,    mon_e.wreg);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid    = 1'b0;
    MemRead_in  = 1'b0;
    MemWrite_in = 1'b0;
    addr_in     = '0;
    wdata_in    = '0;
    mem_rdata   = '0;
    mem_done    = 1'b0;
    mem_err     = 1'b0;
  endtask

  // Drive one EX/MEM instruction and its passthrough fields.
  task automatic drive_op(input logic rd, input logic wr, input logic [DW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] alu,
                          input logic [WW-1:0] wreg);
    in_valid    = 1'b1;
    MemRead_in  = rd;
    MemWrite_in = wr;
    addr_in     = addr;
    wdata_in    = wdata;
    alu_in      = alu;
    pc_in       = alu ^ 16'h5A5A;
    Binput_in   = ~alu;
    RegSrc_in   = rd ? RS_MEM : RS_ALU;
    RegWrt_in   = ~wr;
    wreg_in     = wreg;
  endtask

  function automatic exp_t mk_exp(input logic [DW-1:0] rd_data);
    exp_t e;
    e.alu    = alu_in;
    e.pc     = pc_in;
    e.b      = Binput_in;
    e.rd     = rd_data;
    e.regsrc = RegSrc_in;
    e.regwrt = RegWrt_in;
    e.wreg   = wreg_in;
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int stall_cnt;
    int en_cnt;
    int busy_cycles;
    logic seen_err;

    alu_in    = '0;
    pc_in     = '0;
    Binput_in = '0;
    RegSrc_in = '0;
    RegWrt_in = 1'b0;
    wreg_in   = '0;
    rst_n     = 1'b0;
    drive_idle();
    #2;
    check("rst_stall",   stall_out, 1'b0);
    check("rst_err",     err_out,   1'b0);
    check("rst_mem_en",  mem_en,    1'b0);
    check("rst_valid",   out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: plain ALU op passes straight through.
    step();
    drive_op(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 3'd1);
    sb.push_back(mk_exp(16'h0000));
    @(negedge clk);
    check("alu_mem_en",  mem_en,    1'b0);
    check("alu_stall",   stall_out, 1'b0);
    check("alu_valid",   out_valid, 1'b1);

    // 2: load hit in the issue cycle.
    step();
    drive_op(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0040, 3'd2);
    mem_done  = 1'b1;
    mem_rdata = 16'hBEEF;
    sb.push_back(mk_exp(16'hBEEF));
    @(negedge clk);
    check("hit_mem_en",  mem_en,    1'b1);
    check("hit_mem_wr",  mem_wr,    1'b0);
    check("hit_addr",    mem_addr,  16'h0040);
    check("hit_stall",   stall_out, 1'b0);
    step();
    drive_idle();
    @(negedge clk);
    check("hit_single_en", mem_en, 1'b0);

    // 3: store miss, completion four cycles after issue.
    step();
    drive_op(1'b0, 1'b1, 16'h0102, 16'h00AA, 16'h0102, 3'd3);
    sb.push_back(mk_exp(16'h0000));
    stall_cnt = 0;
    en_cnt    = 0;
    for (int c = 0; c <= 4; c++) begin
      mem_done = (c == 4);
      @(negedge clk);
      if (stall_out) stall_cnt++;
      if (mem_en)    en_cnt++;
      if (c == 0) begin
        check("st_mem_wr", mem_wr,    1'b1);
        check("st_addr",   mem_addr,  16'h0102);
        check("st_wdata",  mem_wdata, 16'h00AA);
      end
      if (c == 4) check("st_valid", out_valid, 1'b1);
      else        check("st_no_valid", out_valid, 1'b0);
      step();
    end
    drive_idle();
    check("st_stall_cycles", stall_cnt, 4);
    check("st_en_pulses",    en_cnt,    1);
    @(negedge clk);
    check("st_back_idle", stall_out, 1'b0);

    // 4: misaligned load goes to the sticky error state without a request.
    step();
    drive_op(1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0003, 3'd4);
    @(negedge clk);
    check("mis_mem_en", mem_en, 1'b0);
    step();
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mis_err",   err_out,   1'b1);
      check("mis_stall", stall_out, 1'b1);
      step();
    end
    do_reset();
    #1;
    check("mis_rst_err",   err_out,   1'b0);
    check("mis_rst_stall", stall_out, 1'b0);

    // mem_err outranks a simultaneous mem_done while BUSY.
    step();
    drive_op(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0030, 3'd5);
    @(negedge clk);
    check("me_issue_stall", stall_out, 1'b1);
    step();
    mem_err   = 1'b1;
    mem_done  = 1'b1;
    mem_rdata = 16'h1111;
    @(negedge clk);
    check("me_no_valid", out_valid, 1'b0);
    step();
    drive_idle();
    @(negedge clk);
    check("me_err", err_out, 1'b1);
    do_reset();

    // 5: load that never completes times out after TO busy cycles.
    step();
    drive_op(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0010, 3'd6);
    busy_cycles = 0;
    seen_err    = 1'b0;
    @(negedge clk);
    check("to_issue_err", err_out, 1'b0);
    for (int c = 1; c <= 20 && !seen_err; c++) begin
      step();
      @(negedge clk);
      if (err_out) begin
        seen_err    = 1'b1;
        busy_cycles = c - 1;
      end
    end
    check("to_reached_err", seen_err,    1'b1);
    check("to_busy_cycles", busy_cycles, TO);
    do_reset();

    // 6: reset during BUSY returns to IDLE; a late mem_done is ignored.
    step();
    drive_op(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0020, 3'd7);
    @(negedge clk);
    check("rb_stall", stall_out, 1'b1);
    step();
    #2;
    rst_n = 1'b0;
    drive_idle();
    #1;
    check("rb_async_stall", stall_out, 1'b0);
    check("rb_async_err",   err_out,   1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_done  = 1'b1;
    mem_rdata = 16'h7777;
    @(negedge clk);
    check("rb_late_done_valid", out_valid, 1'b0);
    check("rb_late_done_en",    mem_en,    1'b0);
    check("rb_late_done_stall", stall_out, 1'b0);
    step();
    drive_idle();
    step();

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
